// File: rtl/fifo_axis_pkg.sv
// Shared constants and helpers for the FIFO <-> AXI4-Stream bridge.
package fifo_axis_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // Width of a counter that must hold 0..pkt_len.
  function automatic int cnt_w(input int pkt_len);
    return $clog2(pkt_len + 1);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer; entry 0 drives out_*. Latency 1 cycle from push to out_valid.
// Backpressure: holds data stable while out_valid && !out_ready; caller must not push when count == BUF_DEPTH.
module axis_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int DW       = 32,
  parameter bit HAS_LAST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic [BUF_CNT_W-1:0] count
);

  localparam int EW = HAS_LAST ? DW + 1 : DW;
  localparam logic [BUF_CNT_W-1:0] FULL = BUF_CNT_W'(BUF_DEPTH);

  logic [EW-1:0] in_ent;
  logic [EW-1:0] ent0;
  logic [EW-1:0] ent1;
  logic          beat;

  // The tlast bit rides along as the top bit of each entry only when framing is built.
  if (HAS_LAST) begin : g_last
    assign in_ent   = {in_last, in_data};
    assign out_last = ent0[DW];
  end else begin : g_nolast
    logic unused_last;
    assign unused_last = in_last;
    assign in_ent      = in_data;
    assign out_last    = 1'b0;
  end

  assign out_valid = (count != '0);
  assign out_data  = ent0[DW-1:0];
  assign beat      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      unique case ({in_valid, beat})
        2'b10: begin
          if (count == '0) ent0 <= in_ent;
          else             ent1 <= in_ent;
          count <= count + 1'b1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == FULL) begin
            ent0 <= ent1;
            ent1 <= in_ent;
          end else begin
            ent0 <= in_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_bridge.sv
// FIFO read port -> AXI4-Stream master (1-cycle latency, 2-entry buffer, tready never reaches fifo_rena);
// AXI4-Stream slave -> FIFO write port (combinational, stalls on fifo_full). Optional framing: FIFO_AXIS_TLAST_EN.
module fifo_axis_bridge
  import fifo_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int PKT_LEN      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_rena,
  output logic [C_DATA_WIDTH-1:0] fifo_wdata,
  input  logic                    fifo_full,
  output logic                    fifo_wena,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready
);

  localparam logic [BUF_CNT_W-1:0] FULL = BUF_CNT_W'(BUF_DEPTH);

  logic [BUF_CNT_W-1:0] buf_cnt;
  logic                 pop_last;

  // Pop decision depends only on registered occupancy; rst gating keeps the FIFO untouched in reset.
  assign fifo_rena = rst && !fifo_empty && (buf_cnt < FULL);

`ifdef FIFO_AXIS_TLAST_EN
  localparam bit HAS_LAST = 1'b1;
  localparam int CW       = cnt_w(PKT_LEN);

  logic [CW-1:0] beat_cnt;
  int            pos;

  // Stream position of the popped word = beats already sent in this packet + entries queued ahead.
  // pos never exceeds PKT_LEN+1, so at most two wraps need matching (only PKT_LEN=1 reaches the third term).
  always_comb begin
    pos      = int'(beat_cnt) + int'(buf_cnt);
    pop_last = (pos == PKT_LEN - 1) || (pos == 2 * PKT_LEN - 1) || (pos == 3 * PKT_LEN - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      beat_cnt <= m_axis_tlast ? '0 : beat_cnt + 1'b1;
    end
  end
`else
  localparam bit HAS_LAST = 1'b0;
  assign pop_last = 1'b0;
`endif

  axis_skid_buf #(
    .DW       (C_DATA_WIDTH),
    .HAS_LAST (HAS_LAST)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_rena),
    .in_data   (fifo_rdata),
    .in_last   (pop_last),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .count     (buf_cnt)
  );

  assign s_axis_tready = !fifo_full;
  assign fifo_wena     = s_axis_tvalid && !fifo_full;
  assign fifo_wdata    = s_axis_tdata;

endmodule
